// File: rtl/data_memory.sv
// data_memory: byte-addressed data memory with byte/half/word stores and
// sign/zero-extended combinational loads. After reset a clearing sweep writes
// zero to every word, and the memory ignores stores until that sweep is done.
// Optional feature macro: DM_MISALIGN_CHK_EN adds a Misalign output. When the
// macro is defined, misaligned halfword/word accesses are flagged, their
// stores are dropped and their loads return zero.

module data_memory #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    input  logic        DmWr,
    input  logic [2:0]  DmCtrl,
    output logic [31:0] DataRd,
    output logic        DmReady
`ifdef DM_MISALIGN_CHK_EN
    ,
    output logic        Misalign
`endif
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_next_s;
    logic              ready_r;

    logic              clear_we_s;
    logic              in_ready_s;
    logic              misalign_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic [ADDR_W-1:0] widx_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       rd_data_s;
    logic              unused_addr_s;

    logic [31:0]       mem_r [DEPTH_WORDS];

    // Sign- or zero-extend a byte.
    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    // Sign- or zero-extend a halfword.
    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

    // Bits above the word index only alias; they are deliberately ignored.
    assign widx_s        = Address[ADDR_W+1:2];
    assign unused_addr_s = ^Address[31:ADDR_W+2];
    assign rd_word_s     = mem_r[widx_s];
    assign DmReady       = ready_r;
    assign DataRd        = rd_data_s;
`ifdef DM_MISALIGN_CHK_EN
    assign Misalign      = misalign_s;
`endif

    // State register: FSM state, clear counter and the registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_CLEAR;
            cnt_r   <= {ADDR_W{1'b0}};
            ready_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            ready_r <= (state_next_s == ST_READY);
        end
    end

    // Next-state logic: sweep every word once, then stay ready until reset.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_CLEAR: begin
                cnt_next_s = cnt_r + ADDR_W'(1);
                if (cnt_r == ADDR_W'(DEPTH_WORDS - 1)) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_READY: begin
                state_next_s = ST_READY;
                cnt_next_s   = cnt_r;
            end
            default: begin
                state_next_s = ST_CLEAR;
                cnt_next_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Output decode: clear write enable, ready qualifier and alignment check.
    always_comb begin
        clear_we_s = 1'b0;
        in_ready_s = 1'b0;
        misalign_s = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                clear_we_s = 1'b1;
                in_ready_s = 1'b0;
            end
            ST_READY: begin
                clear_we_s = 1'b0;
                in_ready_s = 1'b1;
            end
            default: begin
                clear_we_s = 1'b0;
                in_ready_s = 1'b0;
            end
        endcase
`ifdef DM_MISALIGN_CHK_EN
        if (in_ready_s) begin
            misalign_s = ((DmCtrl[1:0] == 2'b01) && Address[0]) ||
                         ((DmCtrl == 3'b010) && (Address[1:0] != 2'b00));
        end else begin
            misalign_s = 1'b0;
        end
`else
        misalign_s = 1'b0;
`endif
    end

    // Store lane decode: byte enables and lane-replicated write data.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = DataWr;
        if (in_ready_s && DmWr && !misalign_s && !rst) begin
            case (DmCtrl)
                3'b000: begin
                    be_s    = 4'b0001 << Address[1:0];
                    wdata_s = {4{DataWr[7:0]}};
                end
                3'b001: begin
                    be_s    = Address[1] ? 4'b1100 : 4'b0011;
                    wdata_s = {2{DataWr[15:0]}};
                end
                3'b010: begin
                    be_s    = 4'b1111;
                    wdata_s = DataWr;
                end
                default: begin
                    be_s    = 4'b0000;
                    wdata_s = DataWr;
                end
            endcase
        end else begin
            be_s    = 4'b0000;
            wdata_s = DataWr;
        end
    end

    // Load path: select and extend from the current array contents.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (in_ready_s && !misalign_s) begin
            case (DmCtrl)
                3'b000, 3'b100: begin
                    case (Address[1:0])
                        2'b00:   rd_data_s = ext_byte(rd_word_s[7:0],   ~DmCtrl[2]);
                        2'b01:   rd_data_s = ext_byte(rd_word_s[15:8],  ~DmCtrl[2]);
                        2'b10:   rd_data_s = ext_byte(rd_word_s[23:16], ~DmCtrl[2]);
                        2'b11:   rd_data_s = ext_byte(rd_word_s[31:24], ~DmCtrl[2]);
                        default: rd_data_s = 32'h0000_0000;
                    endcase
                end
                3'b001, 3'b101: begin
                    if (Address[1]) begin
                        rd_data_s = ext_half(rd_word_s[31:16], ~DmCtrl[2]);
                    end else begin
                        rd_data_s = ext_half(rd_word_s[15:0], ~DmCtrl[2]);
                    end
                end
                3'b010:  rd_data_s = rd_word_s;
                default: rd_data_s = 32'h0000_0000;
            endcase
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    // Memory array: the clearing sweep has priority, otherwise lane stores.
    always_ff @(posedge clk) begin
        if (clear_we_s) begin
            mem_r[cnt_r] <= 32'h0000_0000;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[widx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory with a 16-word array.
module tb_data_memory;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic        DmWr;
    logic [2:0]  DmCtrl;
    logic [31:0] DataRd;
    logic        DmReady;
`ifdef DM_MISALIGN_CHK_EN
    logic        Misalign;
`endif

    int vectors = 0;
    int errors  = 0;

    localparam logic [2:0] C_B  = 3'b000;
    localparam logic [2:0] C_H  = 3'b001;
    localparam logic [2:0] C_W  = 3'b010;
    localparam logic [2:0] C_BU = 3'b100;
    localparam logic [2:0] C_HU = 3'b101;

    data_memory #(.DEPTH_WORDS(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .Address (Address),
        .DataWr  (DataWr),
        .DmWr    (DmWr),
        .DmCtrl  (DmCtrl),
        .DataRd  (DataRd),
        .DmReady (DmReady)
`ifdef DM_MISALIGN_CHK_EN
        ,
        .Misalign(Misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] c);
        DmWr    = 1'b0;
        Address = a;
        DmCtrl  = c;
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        Address = a;
        DataWr  = d;
        DmCtrl  = c;
        DmWr    = 1'b1;
        tick();
        DmWr    = 1'b0;
    endtask

    // DmReady must stay low for DEPTH cycles after release, then rise.
    task automatic clear_wait(input string tag);
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            chk(tag, {31'd0, DmReady}, (k == DEPTH) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; Address = 32'h0; DataWr = 32'h0; DmWr = 1'b0; DmCtrl = C_W;
        tick();
        tick();
        load(32'h0, C_W);
        chk("reset_ready", {31'd0, DmReady}, 32'd0);
        chk("reset_rd", DataRd, 32'h0);
        rst = 1'b0;
        clear_wait("clear_ready");

        for (int w = 0; w < DEPTH; w++) begin
            load(32'(w * 4), C_W);
            chk("cleared_word", DataRd, 32'h0);
        end

        // Word store then every load flavour.
        store(32'h40, 32'h80F1_7F02, C_W);
        load(32'h40, C_W);  chk("lw_40",  DataRd, 32'h80F1_7F02);
        load(32'h40, C_B);  chk("lb_40",  DataRd, 32'h0000_0002);
        load(32'h43, C_B);  chk("lb_43",  DataRd, 32'hFFFF_FF80);
        load(32'h43, C_BU); chk("lbu_43", DataRd, 32'h0000_0080);
        load(32'h42, C_H);  chk("lh_42",  DataRd, 32'hFFFF_80F1);
        load(32'h42, C_HU); chk("lhu_42", DataRd, 32'h0000_80F1);
        load(32'h41, C_B);  chk("lb_41",  DataRd, 32'h0000_007F);
        load(32'h40, C_H);  chk("lh_40",  DataRd, 32'h0000_7F02);

        // Lane stores; upper DataWr bits must not leak into other lanes.
        store(32'h10, 32'h0000_0000, C_W);
        store(32'h11, 32'h1234_56AB, C_B);
        store(32'h12, 32'h7777_BEEF, C_H);
        load(32'h10, C_W);  chk("lanes_10", DataRd, 32'hBEEF_AB00);

        // Read during write: old data before the edge, new after.
        store(32'h20, 32'h1111_1111, C_W);
        Address = 32'h20; DataWr = 32'h2222_2222; DmCtrl = C_W; DmWr = 1'b1;
        #1;
        chk("rdw_before", DataRd, 32'h1111_1111);
        tick();
        chk("rdw_after", DataRd, 32'h2222_2222);
        DmWr = 1'b0;

        // Unsupported codes: no write, load returns zero.
        store(32'h20, 32'hDEAD_BEEF, 3'b011);
        store(32'h20, 32'hDEAD_BEEF, 3'b110);
        load(32'h20, C_W);   chk("ctrl011_nowr", DataRd, 32'h2222_2222);
        load(32'h20, 3'b110); chk("ld_110_zero", DataRd, 32'h0);
        load(32'h20, 3'b011); chk("ld_011_zero", DataRd, 32'h0);

        // Address wrap modulo 4*DEPTH.
        store(32'h40 + 32'(4 * DEPTH), 32'h55AA_55AA, C_W);
        load(32'h40, C_W);  chk("wrap_40", DataRd, 32'h55AA_55AA);
        load(32'h00, C_W);  chk("wrap_00", DataRd, 32'h55AA_55AA);

`ifdef DM_MISALIGN_CHK_EN
        Address = 32'h41; DataWr = 32'hFFFF_FFFF; DmCtrl = C_W; DmWr = 1'b1;
        #1;
        chk("mis_sw41_flag", {31'd0, Misalign}, 32'd1);
        tick();
        DmWr = 1'b0;
        load(32'h40, C_W);  chk("mis_sw41_mem", DataRd, 32'h55AA_55AA);
        chk("mis_lw40_flag", {31'd0, Misalign}, 32'd0);
        load(32'h43, C_H);
        chk("mis_lh43_flag", {31'd0, Misalign}, 32'd1);
        chk("mis_lh43_rd", DataRd, 32'h0);
        load(32'h42, C_H);
        chk("mis_lh42_flag", {31'd0, Misalign}, 32'd0);
        chk("mis_lh42_rd", DataRd, 32'h0000_55AA);
`else
        load(32'h43, C_H);  chk("lh43_ignore_a0", DataRd, 32'h0000_55AA);
        store(32'h43, 32'h0102_0304, C_W);
        load(32'h40, C_W);  chk("sw43_ignore_a10", DataRd, 32'h0102_0304);
`endif

        // Reset mid-clear with stores attempted during CLEAR.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        Address = 32'h0; DataWr = 32'hCAFE_F00D; DmCtrl = C_W; DmWr = 1'b1;
        #1;
        chk("clear_rd_zero", DataRd, 32'h0);
`ifdef DM_MISALIGN_CHK_EN
        Address = 32'h1;
        #1;
        chk("clear_mis_zero", {31'd0, Misalign}, 32'd0);
        Address = 32'h0;
`endif
        for (int k = 0; k < 7; k++) tick();
        chk("midclear_ready", {31'd0, DmReady}, 32'd0);
        DmWr = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_wait("restart_ready");
        load(32'h00, C_W);  chk("early_sw_ignored", DataRd, 32'h0);
        load(32'h20, C_W);  chk("restart_cleared", DataRd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Data memory stage directly downstream of the single-cycle control unit.
- Consumes DmWr and DmCtrl (func3 of load/store) from the control unit, and the ALU result as the byte address.
- Performs byte/half/word stores on the clock edge. Returns sign- or zero-extended load data combinationally, so loads complete in the same cycle.
- After reset, a clearing state machine zeroes every word before the memory accepts stores.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- ADDR_W, $clog2(DEPTH_WORDS), word-index width, taken from Address[ADDR_W+1:2].

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Address  in  32  byte address (ALU result).
- DataWr  in  32  store data (rs2); low byte/half used for SB/SH.
- DmWr  in  1  store enable from the control unit.
- DmCtrl  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- DataRd  out  32  load data, extended per DmCtrl.
- DmReady  out  1  high once clearing is complete.

Behaviour:
- Reset (sampled on the rising edge while rst=1):
  - FSM goes to CLEAR; clear counter goes to 0; DmReady=0.
  - DataRd reads 0 while in CLEAR.
  - Asserting rst mid-CLEAR restarts the counter at 0.
- FSM:
  - CLEAR: each cycle write 0 to word[counter] and increment. On the cycle counter==DEPTH_WORDS-1 is written, go to READY.
  - Clearing takes exactly DEPTH_WORDS cycles after rst deasserts.
  - READY: DmReady=1. Stays in READY until rst.
- Stores and loads in CLEAR:
  - Stores are ignored; DmWr has no effect.
  - DataRd=0 regardless of Address.
- Word index is Address[ADDR_W+1:2]. Higher bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Store (READY, DmWr=1), written on the rising edge with byte-lane enables:
  - 000 SB: byte lane Address[1:0] ← DataWr[7:0].
  - 001 SH: half Address[1] ← DataWr[15:0].
  - 010 SW: full word ← DataWr.
  - Other DmCtrl codes: no write.
- Load (combinational from the current array contents; DmWr=0 or 1):
  - 000 LB: byte at Address[1:0], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half at Address[1], sign-extended.
  - 101 LHU: same half, zero-extended.
  - 010 LW: full word.
  - Other codes (011, 110, 111): DataRd=0.
- Read during write to the same address: DataRd shows the old contents until the edge and the new contents after it. There is no bypass.
- Misalignment handling without the feature:
  - Halfwords ignore Address[0].
  - Words ignore Address[1:0].
- X or undefined DmCtrl from the control unit on non-memory instructions: DmWr=0 guarantees no write; DataRd is don't-care (unused by the writeback mux).
- The array has no reset other than the CLEAR sweep.

Optional Feature:
- Macro: DM_MISALIGN_CHK_EN.
- When defined:
  - Adds output port Misalign (1 bit, combinational).
  - Misalign=1 when in READY and either (DmCtrl[1:0]=01 and Address[0]=1) or (DmCtrl=010 and Address[1:0]≠00).
  - On a misaligned access the store is suppressed and DataRd=0.
  - Misalign=0 in CLEAR.
- When undefined: the port is absent and the low address bits are ignored as described in Behaviour.

Test Plan:
- Reset clearing: assert rst for 2 cycles with DEPTH_WORDS=16, then release.
  - DmReady=0 for exactly 16 cycles, then 1.
  - LW from every word returns 0x00000000.
- SW then loads: SW 0x80F1_7F02 to 0x40.
  - LW 0x40 → 0x80F17F02.
  - LB 0x40 → 0x00000002.
  - LB 0x43 → 0xFFFFFF80.
  - LBU 0x43 → 0x00000080.
  - LH 0x42 → 0xFFFF80F1.
  - LHU 0x42 → 0x000080F1.
- Lane stores: SW 0 to 0x10, then SB 0xAB to 0x11, then SH 0xBEEF to 0x12 → LW 0x10 → 0xBEEFAB00.
- Write-during-read and ignored stores:
  - LW 0x20 holding 0x11111111 while SW 0x22222222 to 0x20 → DataRd=0x11111111 before the edge, 0x22222222 after.
  - DmCtrl=011 with DmWr=1 → no change to memory.
- Reset mid-clear and early stores:
  - SW during CLEAR is ignored.
  - rst asserted at clear count 7 → clearing restarts and DmReady rises 16 cycles after release.
  - Wrap: SW to 0x40+4*16 aliases word 0x40 (DEPTH_WORDS=16).
- With DM_MISALIGN_CHK_EN: SW to 0x41 → Misalign=1 and memory unchanged; LH 0x43 → Misalign=1, DataRd=0; LH 0x42 → Misalign=0.
